board_move_reader: RTL and testbench

- Board-level consumer of the eight column move FIFOs: the read side of the column collection path.
- Waits for each column's done, drains that column's 160-bit FIFO words in file order a..h, and unpacks every word into 19-bit move records.
- Presents valid records one at a time on a valid/ready stream to the downstream search/host interface.
- Counts emitted moves, enforces a watchdog, and signals board-pass completion.

---
 rtl/chess_move_pkg.sv | 39 +++
 rtl/move_unpacker.sv | 58 +++++
 rtl/board_move_reader.sv | 149 ++++++++++++++
 tb/tb_board_move_reader.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_move_pkg.sv
// Shared move-record layout and reader state encoding for the column collection path.
package chess_move_pkg;

  localparam int unsigned NCOL   = 8;
  localparam int unsigned MOVE_W = 19;
  localparam int unsigned SLOTS  = 8;
  localparam int unsigned WORD_W = 160;

  // Flag bits of a move record
  localparam int unsigned INVALID = 18;
  localparam int unsigned PROMOTE = 17;
  localparam int unsigned PAWN    = 16;
  localparam int unsigned PAWN2   = 15;
  localparam int unsigned EP      = 14;
  localparam int unsigned CASTLE  = 13;
  localparam int unsigned CAPTURE = 12;

  // Square fields
  localparam int unsigned FROM_HI = 11;
  localparam int unsigned FROM_LO = 6;
  localparam int unsigned TO_HI   = 5;
  localparam int unsigned TO_LO   = 0;

  typedef logic [MOVE_W-1:0] move_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_READ,
    ST_LATCH,
    ST_EMIT,
    ST_DONE
  } reader_state_e;

  function automatic logic move_is_invalid(input move_t m);
    return m[INVALID];
  endfunction

endpackage

// File: rtl/move_unpacker.sv
// Holds one column FIFO word and walks its eight slots, skipping invalid
// records and presenting valid ones on a valid/ready stream.
module move_unpacker
  import chess_move_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              flush,
  input  logic              move_ready,
  output logic [MOVE_W-1:0] move_out,
  output logic              move_valid,
  output logic              word_done
);

  logic [WORD_W-1:0] word_q;
  logic [2:0]        slot_q;
  logic              active_q;
  move_t             rec;
  logic              advance;

  // Current slot record; reserved bits [159:152] are never selected
  always_comb begin
    rec = word_q[32'(slot_q) * MOVE_W +: MOVE_W];
  end

  // Output stage: valid depends only on registered state, never on ready
  always_comb begin
    move_valid = active_q && !move_is_invalid(rec);
    move_out   = move_valid ? rec : '0;
    advance    = active_q && (move_is_invalid(rec) || move_ready);
    word_done  = advance && (slot_q == 3'(SLOTS - 1));
  end

  // Word buffer and slot counter; flush drops any in-flight word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q   <= '0;
      slot_q   <= '0;
      active_q <= 1'b0;
    end else if (flush) begin
      word_q   <= '0;
      slot_q   <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      word_q   <= word;
      slot_q   <= '0;
      active_q <= 1'b1;
    end else if (advance) begin
      slot_q <= slot_q + 3'd1;
      if (slot_q == 3'(SLOTS - 1)) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/board_move_reader.sv
// Board-level reader: drains column FIFOs a..h in order once each column is
// done, unpacks move records, counts them and guards the pass with a watchdog.
module board_move_reader
  import chess_move_pkg::*;
#(
  parameter int unsigned NCOL_P  = NCOL,
  parameter logic [15:0] WDT_VAL = 16'd4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NCOL_P-1:0]        col_done,
  input  logic [NCOL_P-1:0]        col_empty,
  output logic [NCOL_P-1:0]        col_rden,
  input  logic [NCOL_P*WORD_W-1:0] col_q,
  output logic [MOVE_W-1:0]        move_out,
  output logic                     move_valid,
  input  logic                     move_ready,
  output logic [7:0]               move_count,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout
);

  localparam int unsigned PTR_W = $clog2(NCOL_P);

  reader_state_e     state_q, state_n;
  logic [PTR_W-1:0]  col_ptr_q;
  logic [15:0]       wdt_q;
  logic              timeout_q;
  logic [NCOL_P-1:0] rden_n;
  logic              ptr_inc;
  logic              load;
  logic              flush;
  logic              start_acc;
  logic              busy_w;
  logic              expire;
  logic              word_done;
  logic [WORD_W-1:0] cur_word;

  // Selected column's FIFO output
  always_comb begin
    cur_word = col_q[32'(col_ptr_q) * WORD_W +: WORD_W];
  end

  // Next-state and control decode; watchdog expiry overrides everything
  always_comb begin
    state_n   = state_q;
    rden_n    = '0;
    ptr_inc   = 1'b0;
    load      = 1'b0;
    flush     = 1'b0;
    start_acc = 1'b0;
    busy_w    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    expire    = busy_w && (wdt_q <= 16'd1);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n   = ST_SCAN;
          start_acc = 1'b1;
        end
      end
      ST_SCAN: begin
        if (col_done[col_ptr_q]) begin
          if (!col_empty[col_ptr_q]) begin
            state_n = ST_READ;
            rden_n  = {{(NCOL_P-1){1'b0}}, 1'b1} << col_ptr_q;
          end else if (col_ptr_q == PTR_W'(NCOL_P - 1)) begin
            state_n = ST_DONE;
          end else begin
            ptr_inc = 1'b1;
          end
        end
      end
      ST_READ:  state_n = ST_LATCH;
      ST_LATCH: begin
        load    = 1'b1;
        state_n = ST_EMIT;
      end
      ST_EMIT: begin
        if (word_done) begin
          state_n = ST_SCAN;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (expire) begin
      state_n = ST_DONE;
      rden_n  = '0;
      ptr_inc = 1'b0;
      load    = 1'b0;
      flush   = 1'b1;
    end
  end

  // State, column pointer, watchdog, move counter and registered read enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      col_ptr_q  <= '0;
      wdt_q      <= '0;
      timeout_q  <= 1'b0;
      move_count <= '0;
      col_rden   <= '0;
    end else begin
      state_q  <= state_n;
      col_rden <= rden_n;
      if (start_acc) begin
        col_ptr_q  <= '0;
        move_count <= '0;
        wdt_q      <= WDT_VAL;
        timeout_q  <= 1'b0;
      end else begin
        if (ptr_inc) begin
          col_ptr_q <= col_ptr_q + PTR_W'(1);
        end
        if (busy_w && (wdt_q != 16'd0)) begin
          wdt_q <= wdt_q - 16'd1;
        end
        if (expire) begin
          timeout_q <= 1'b1;
        end
        if (move_valid && move_ready && (move_count != 8'hFF)) begin
          move_count <= move_count + 8'd1;
        end
      end
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy    = busy_w;
    done    = (state_q == ST_DONE);
    timeout = timeout_q;
  end

  move_unpacker u_unpacker (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .word       (cur_word),
    .flush      (flush),
    .move_ready (move_ready),
    .move_out   (move_out),
    .move_valid (move_valid),
    .word_done  (word_done)
  );

endmodule

// File: tb/tb_board_move_reader.sv
// Randomized bench for board_move_reader with a FIFO model and a queue-based
// expectation of read order and emitted moves.
`timescale 1ns/100ps
module tb_board_move_reader;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          start_w = 1'b0;
  logic          move_ready = 1'b0;
  logic [7:0]    col_done = '0;
  logic [7:0]    col_empty;
  logic [1279:0] col_q = '0;

  logic [7:0]  col_rden, col_rden_w;
  logic [18:0] move_out, move_out_w;
  logic        move_valid, move_valid_w;
  logic [7:0]  move_count, move_count_w;
  logic        busy, busy_w, done, done_w, timeout, timeout_w;

  always #5 clk = ~clk;

  board_move_reader dut (
    .clk(clk), .reset(reset), .start(start), .col_done(col_done),
    .col_empty(col_empty), .col_rden(col_rden), .col_q(col_q),
    .move_out(move_out), .move_valid(move_valid), .move_ready(move_ready),
    .move_count(move_count), .busy(busy), .done(done), .timeout(timeout)
  );

  board_move_reader #(.WDT_VAL(16'd50)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .col_done(col_done),
    .col_empty(col_empty), .col_rden(col_rden_w), .col_q(col_q),
    .move_out(move_out_w), .move_valid(move_valid_w), .move_ready(move_ready),
    .move_count(move_count_w), .busy(busy_w), .done(done_w), .timeout(timeout_w)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: registered output, data valid the cycle after rden
  logic [159:0] fifo_mem [8][64];
  int           wr_cnt [8];
  int           rd_cnt [8];
  logic         fifo_clr = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (fifo_clr) rd_cnt[i] <= 0;
      else if (col_rden[i] && rd_cnt[i] < wr_cnt[i]) begin
        col_q[i*160 +: 160] <= fifo_mem[i][rd_cnt[i]];
        rd_cnt[i] <= rd_cnt[i] + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) col_empty[i] = (rd_cnt[i] == wr_cnt[i]);
  end

  // Downstream ready: 0 low, 1 high, otherwise random
  int ready_mode = 1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       move_ready = 1'b0;
      1:       move_ready = 1'b1;
      default: move_ready = ($urandom_range(3, 0) != 0);
    endcase
  end

  // Reference expectations
  logic [18:0] mv_q [$];
  int          rden_q [$];
  int          exp_total;
  int          hs_total = 0;
  int          hs_base;
  logic        mon_en = 1'b0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [18:0] prev_out = '0;
  logic [7:0]  prev_rden = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_rden != 0) check("rden_one_cycle", 32'(col_rden), 32'(0));
      if (col_rden != 0) begin
        if (rden_q.size() == 0) check("rden_extra", 32'(col_rden), 32'(0));
        else check("rden_order", 32'(col_rden), 32'(8'h01 << rden_q.pop_front()));
      end
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 32'(move_valid), 32'(1));
        check("hold_out", 32'(move_out), 32'(prev_out));
      end
      if (move_valid && move_ready) begin
        hs_total <= hs_total + 1;
        if (mv_q.size() == 0) check("move_extra", 32'(mv_q.size()), 32'(1));
        else check("move", 32'(move_out), 32'(mv_q.pop_front()));
      end
      prev_valid <= move_valid;
      prev_ready <= move_ready;
      prev_out   <= move_out;
      prev_rden  <= col_rden;
    end else begin
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
      prev_rden  <= '0;
    end
  end

  function automatic logic [18:0] rand_rec(input int unsigned pct_invalid);
    logic [18:0] r;
    r = 19'($urandom);
    r[18] = ($urandom_range(99, 0) < pct_invalid);
    return r;
  endfunction

  function automatic logic [159:0] rand_word(input int unsigned pct_invalid);
    logic [159:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[k*19 +: 19] = rand_rec(pct_invalid);
    w[159:152] = 8'($urandom);
    return w;
  endfunction

  task automatic clear_fifos();
    for (int i = 0; i < 8; i++) wr_cnt[i] = 0;
    fifo_clr = 1'b1;
    @(posedge clk);
    #1 fifo_clr = 1'b0;
  endtask

  task automatic push_word(input int c, input logic [159:0] w);
    fifo_mem[c][wr_cnt[c]] = w;
    wr_cnt[c] = wr_cnt[c] + 1;
  endtask

  // Files a..h in order, every word in FIFO order, valid slots 0..7
  task automatic build_expect();
    logic [159:0] wd;
    logic [18:0]  rec;
    mv_q.delete();
    rden_q.delete();
    exp_total = 0;
    for (int c = 0; c < 8; c++) begin
      for (int w = 0; w < wr_cnt[c]; w++) begin
        rden_q.push_back(c);
        wd = fifo_mem[c][w];
        for (int k = 0; k < 8; k++) begin
          rec = wd[k*19 +: 19];
          if (!rec[18]) begin
            mv_q.push_back(rec);
            exp_total++;
          end
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic begin_pass(input int da [8]);
    build_expect();
    hs_base = hs_total;
    col_done = '0;
    for (int c = 0; c < 8; c++) if (da[c] == 0) col_done[c] = 1'b1;
    mon_en = 1'b1;
    pulse_start();
    check("start_done_clr", 32'(done), 32'(0));
    check("start_cnt_clr", 32'(move_count), 32'(0));
  endtask

  task automatic finish_pass(input int da [8], input int mid_start, input int budget);
    int cyc;
    int want;
    cyc = 0;
    while (!done && cyc < budget) begin
      for (int c = 0; c < 8; c++) if (cyc >= da[c]) col_done[c] = 1'b1;
      start = (cyc == mid_start) && busy;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("pass_done", 32'(done), 32'(1));
    repeat (2) @(negedge clk);
    want = (exp_total > 255) ? 255 : exp_total;
    check("move_count", 32'(move_count), 32'(want));
    check("handshakes", 32'(hs_total - hs_base), 32'(exp_total));
    check("no_timeout", 32'(timeout), 32'(0));
    check("not_busy", 32'(busy), 32'(0));
    check("moves_left", 32'(mv_q.size()), 32'(0));
    check("reads_left", 32'(rden_q.size()), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: observed running expected finished");
    $fatal(1);
  end

  initial begin
    int da [8];
    int n;
    logic [159:0] w;
    logic [7:0]   rd_seen;

    // Reset state for both instances
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rden", 32'(col_rden), 32'(0));
    check("rst_out", 32'(move_out), 32'(0));
    check("rst_valid", 32'(move_valid), 32'(0));
    check("rst_count", 32'(move_count), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_timeout", 32'(timeout), 32'(0));
    check("rst_w_flags", 32'({col_rden_w, move_valid_w, busy_w, done_w, timeout_w}), 32'(0));
    check("rst_w_data", 32'({move_out_w, move_count_w}), 32'(0));
    reset = 1'b1;
    @(negedge clk);

    for (int c = 0; c < 8; c++) da[c] = 0;

    // Single move in column a
    clear_fifos();
    w = rand_word(100);
    w[18:0] = 19'h0031C;
    push_word(0, w);
    ready_mode = 1;
    begin_pass(da);
    finish_pass(da, -1, 300);

    // Backpressure on one presented move
    clear_fifos();
    w = rand_word(100);
    w[2*19 +: 19] = rand_rec(0);
    push_word(0, w);
    ready_mode = 0;
    begin_pass(da);
    n = 0;
    while (!move_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", 32'(move_valid), 32'(1));
    repeat (5) begin
      @(negedge clk);
      check("bp_count_hold", 32'(move_count), 32'(0));
    end
    ready_mode = 1;
    finish_pass(da, -1, 300);

    // Column h done first, column a 20 cycles later
    clear_fifos();
    push_word(0, rand_word(40));
    push_word(7, rand_word(40));
    da[0] = 20;
    begin_pass(da);
    finish_pass(da, -1, 400);
    da[0] = 0;

    // Three full words in column d
    clear_fifos();
    for (int i = 0; i < 3; i++) push_word(3, rand_word(0));
    begin_pass(da);
    finish_pass(da, -1, 400);

    // Random passes with late column dones and a start while busy
    ready_mode = 2;
    for (int p = 0; p < 6; p++) begin
      clear_fifos();
      for (int c = 0; c < 8; c++) begin
        n = $urandom_range(3, 0);
        for (int i = 0; i < n; i++) push_word(c, rand_word(30));
        da[c] = $urandom_range(40, 0);
      end
      begin_pass(da);
      finish_pass(da, 3, 2000);
    end
    for (int c = 0; c < 8; c++) da[c] = 0;

    // Move counter saturation
    clear_fifos();
    for (int c = 0; c < 8; c++) for (int i = 0; i < 5; i++) push_word(c, rand_word(0));
    begin_pass(da);
    finish_pass(da, -1, 3500);

    // Watchdog: column c never done
    clear_fifos();
    col_done = 8'hFB;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk) start_w = 1'b1;
      @(negedge clk) start_w = 1'b0;
      check("wdt_start_clr", 32'({done_w, timeout_w}), 32'(0));
      n = 1;
      while (!done_w && n < 200) begin
        @(posedge clk);
        #1;
        if (!done_w) n++;
      end
      check("wdt_cycles", 32'(n), 32'(50));
      check("wdt_timeout", 32'(timeout_w), 32'(1));
      check("wdt_busy", 32'(busy_w), 32'(0));
      check("wdt_valid", 32'(move_valid_w), 32'(0));
      check("wdt_count", 32'(move_count_w), 32'(0));
      rd_seen = '0;
      repeat (10) begin
        @(negedge clk);
        rd_seen = rd_seen | col_rden_w;
      end
      check("wdt_no_rden", 32'(rd_seen), 32'(0));
      check("wdt_held", 32'({done_w, timeout_w}), 32'(3));
    end

    // Async reset while a read enable is high
    mon_en = 1'b0;
    clear_fifos();
    push_word(0, rand_word(0));
    col_done = 8'hFF;
    ready_mode = 0;
    pulse_start();
    n = 0;
    while (col_rden == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_rd_seen", 32'(col_rden), 32'(8'h01));
    #2 reset = 1'b0;
    #0.5;
    check("arst_rden", 32'(col_rden), 32'(0));
    check("arst_busy_rd", 32'(busy), 32'(0));
    #0.5 reset = 1'b1;

    // Async reset mid-EMIT after a couple of handshakes
    clear_fifos();
    push_word(0, rand_word(0));
    pulse_start();
    ready_mode = 1;
    n = 0;
    while (move_count < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ready_mode = 0;
    repeat (2) @(negedge clk);
    check("emit_valid", 32'(move_valid), 32'(1));
    check("emit_count", 32'(move_count >= 8'd2), 32'(1));
    #2 reset = 1'b0;
    #0.5;
    check("arst_valid", 32'(move_valid), 32'(0));
    check("arst_out", 32'(move_out), 32'(0));
    check("arst_count", 32'(move_count), 32'(0));
    check("arst_rden2", 32'(col_rden), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    #0.5 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", 32'({busy, done, move_valid}), 32'(0));
    check("idle_count", 32'(move_count), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
